// File: rtl/icache_pkg.sv
`default_nettype none
// icache_pkg: shared state encoding and default geometry for the instruction cache.
// Revision: 1.0
package icache_pkg;

  typedef enum logic {
    IC_IDLE = 1'b0,
    IC_MISS = 1'b1
  } ic_state_t;

  localparam int ICACHE_INDEX_BITS = 6;

endpackage
`default_nettype wire

// File: rtl/icache_array.sv
`default_nettype none
// icache_array: valid/tag/data storage, async read port, sync write port, valid cleared on rst.
// Revision: 1.0
module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [31:0]           rd_data,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [31:0]           wr_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [LINES];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (we) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tag/data need no reset: they are never trusted while the line is invalid.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

endmodule
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// icache: direct-mapped, one-word-per-line instruction cache (FSM, hit compare, output registers).
// Revision: 1.0
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        fetch_en,
  input  logic [31:0] fetch_pc,
  input  logic        clear,
  output logic        fetch_hit,
  output logic [31:0] fetch_inst,
  output logic        inst_miss,
  output logic [31:0] miss_pc,
  input  logic        mem_inst_rdy,
  input  logic [31:0] mem_inst
);

  localparam int TAG_BITS = 30 - INDEX_BITS;

  ic_state_t state, state_next;

  logic                  fetch_hit_next;
  logic [31:0]           fetch_inst_next;
  logic                  inst_miss_next;
  logic [31:0]           miss_pc_next;
  logic                  fill;
  logic                  lookup_hit;
  logic                  accept;
  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [31:0]           rd_data;
  logic [INDEX_BITS-1:0] fetch_index;
  logic [TAG_BITS-1:0]   fetch_tag;
  logic                  unused_pc_bits;

  assign fetch_index    = fetch_pc[INDEX_BITS+1:2];
  assign fetch_tag      = fetch_pc[31:INDEX_BITS+2];
  assign unused_pc_bits = ^fetch_pc[1:0];

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_index (fetch_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .we       (fill && rdy && !rst),
    .wr_index (miss_pc[INDEX_BITS+1:2]),
    .wr_tag   (miss_pc[31:INDEX_BITS+2]),
    .wr_data  (mem_inst)
  );

  assign lookup_hit = rd_valid && (rd_tag == fetch_tag);
  // fetch_hit=0 keeps a held PC from being answered a second time.
  assign accept     = fetch_en && !clear && !fetch_hit;

  always_comb begin
    state_next      = state;
    fetch_hit_next  = 1'b0;
    fetch_inst_next = fetch_inst;
    inst_miss_next  = inst_miss;
    miss_pc_next    = miss_pc;
    fill            = 1'b0;
    case (state)
      IC_IDLE: begin
        if (accept) begin
          if (lookup_hit) begin
            fetch_hit_next  = 1'b1;
            fetch_inst_next = rd_data;
          end else begin
            inst_miss_next = 1'b1;
            miss_pc_next   = {fetch_pc[31:2], 2'b00};
            state_next     = IC_MISS;
          end
        end
      end
      IC_MISS: begin
        // Data returned alongside a flush still belongs to miss_pc, so keep it.
        fill = mem_inst_rdy;
        if (clear) begin
          inst_miss_next = 1'b0;
          state_next     = IC_IDLE;
        end else if (mem_inst_rdy) begin
          fetch_hit_next  = 1'b1;
          fetch_inst_next = mem_inst;
          inst_miss_next  = 1'b0;
          state_next      = IC_IDLE;
        end
      end
      default: state_next = IC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IC_IDLE;
      fetch_hit  <= 1'b0;
      fetch_inst <= 32'h0;
      inst_miss  <= 1'b0;
      miss_pc    <= 32'h0;
    end else if (rdy) begin
      state      <= state_next;
      fetch_hit  <= fetch_hit_next;
      fetch_inst <= fetch_inst_next;
      inst_miss  <= inst_miss_next;
      miss_pc    <= miss_pc_next;
    end
  end

endmodule
`default_nettype wire
